// File: rtl/riscv_cpu_pkg.sv
// Shared ISA encodings, ALU operation set and the ALU evaluation function
// used by the riscv_cpu datapath.
package riscv_cpu_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MUL
  } alu_op_t;

  function automatic logic [31:0] alu_exec(alu_op_t op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      ALU_MUL:  return a * b;
      default:  return a + b;
    endcase
  endfunction

endpackage

// File: rtl/riscv_cpu_exec.sv
// Combinational decode/execute for one instruction plus the register file.
// Produces next PC, data-memory address/lanes and the halt request for the top.
module riscv_cpu_exec
  import riscv_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        commit,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] load_word,
  output logic [31:0] next_pc,
  output logic [31:0] mem_addr,
  output logic [31:0] store_data,
  output logic [3:0]  store_mask,
  output logic        halt
);
  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, alu_b, alu_y, ld_val, wdata;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;
  alu_op_t     alu_op;
  logic        alu_ok, ld_ok, take, wen;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  riscv_cpu_rf rf (
    .clk    (clk),
    .reset  (reset),
    .we     (commit && wen),
    .waddr  (rd),
    .wdata  (wdata),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  assign alu_b    = (opcode == OP_IMM) ? imm_i : rs2_val;
  assign alu_y    = alu_exec(alu_op, rs1_val, alu_b);
  assign mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);

  // funct7 legality differs between register and immediate forms
  always_comb begin
    alu_op = ALU_ADD;
    case (f3)
      3'b000:  alu_op = (opcode == OP_REG && f7 == F7_ALT) ? ALU_SUB :
                        (opcode == OP_REG && f7 == F7_MUL) ? ALU_MUL : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
    if (opcode == OP_REG)
      alu_ok = (f7 == F7_BASE) || (f7 == F7_MUL && f3 == 3'b000) ||
               (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
    else
      alu_ok = (f3 != 3'b001 && f3 != 3'b101) || (f7 == F7_BASE) ||
               (f7 == F7_ALT && f3 == 3'b101);
  end

  always_comb begin
    case (f3)
      F3_BEQ:  take = rs1_val == rs2_val;
      F3_BNE:  take = rs1_val != rs2_val;
      F3_BLT:  take = $signed(rs1_val) < $signed(rs2_val);
      F3_BGE:  take = $signed(rs1_val) >= $signed(rs2_val);
      F3_BLTU: take = rs1_val < rs2_val;
      F3_BGEU: take = rs1_val >= rs2_val;
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    case (mem_addr[1:0])
      2'd0:    ld_byte = load_word[7:0];
      2'd1:    ld_byte = load_word[15:8];
      2'd2:    ld_byte = load_word[23:16];
      default: ld_byte = load_word[31:24];
    endcase
    ld_half = mem_addr[1] ? load_word[31:16] : load_word[15:0];
    ld_ok   = 1'b1;
    case (f3)
      F3_B:    ld_val = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_val = {24'b0, ld_byte};
      F3_H:    ld_val = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_val = {16'b0, ld_half};
      F3_W:    ld_val = load_word;
      default: begin ld_val = load_word; ld_ok = 1'b0; end
    endcase
  end

  // Store data is replicated across lanes; the mask picks the lanes written.
  always_comb begin
    store_mask = 4'b0000;
    store_data = rs2_val;
    if (opcode == OP_STORE) begin
      case (f3)
        F3_B: begin
          store_mask = 4'b0001 << mem_addr[1:0];
          store_data = {4{rs2_val[7:0]}};
        end
        F3_H: begin
          store_mask = mem_addr[1] ? 4'b1100 : 4'b0011;
          store_data = {2{rs2_val[15:0]}};
        end
        F3_W:    store_mask = 4'b1111;
        default: store_mask = 4'b0000;
      endcase
    end
  end

  always_comb begin
    next_pc = pc + 32'd4;
    wen     = 1'b0;
    wdata   = alu_y;
    halt    = 1'b0;
    case (opcode)
      OP_LUI:    begin wen = 1'b1; wdata = imm_u; end
      OP_AUIPC:  begin wen = 1'b1; wdata = pc + imm_u; end
      OP_JAL:    begin wen = 1'b1; wdata = pc + 32'd4; next_pc = pc + imm_j; end
      OP_JALR:   begin wen = 1'b1; wdata = pc + 32'd4; next_pc = (rs1_val + imm_i) & ~32'd1; end
      OP_BRANCH: if (take) next_pc = pc + imm_b;
      OP_LOAD:   begin wen = ld_ok; wdata = ld_val; end
      OP_IMM,
      OP_REG:    wen = alu_ok;
      OP_SYSTEM: begin halt = 1'b1; next_pc = pc; end
      default:   wen = 1'b0;
    endcase
  end
endmodule

// File: rtl/riscv_cpu_rf.sv
// 32x32 register file: two combinational read ports, one synchronous write port.
// x0 is never written, so it always reads zero; same-cycle reads see the old value.
module riscv_cpu_rf (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] regs [0:31];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];
endmodule

// File: rtl/riscv_cpu.sv
// Single-cycle RV32I + MUL core: fetch, PC, memories and cycle counter.
// One instruction commits per rising edge; ECALL/EBREAK freezes state until reset.
module riscv_cpu #(
  parameter string MEMFILE    = "program.mem",
  parameter int    IMEM_WORDS = 256,
  parameter int    DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] cycle_count
);
  localparam int IA = $clog2(IMEM_WORDS);
  localparam int DA = $clog2(DMEM_WORDS);

  logic [31:0] imem [0:IMEM_WORDS-1];
  logic [31:0] dmem [0:DMEM_WORDS-1];
  logic [31:0] pc, instr, next_pc, mem_addr, store_data, load_word;
  logic [3:0]  store_mask;
  logic        halt, halted;
  logic        unused_addr_bits;

  assign instr            = imem[pc[IA+1:2]];
  assign load_word        = dmem[mem_addr[DA+1:2]];
  assign unused_addr_bits = ^{mem_addr[31:DA+2], mem_addr[1:0]};

  riscv_cpu_exec exec_unit (
    .clk        (clk),
    .reset      (reset),
    .commit     (!halted),
    .instr      (instr),
    .pc         (pc),
    .load_word  (load_word),
    .next_pc    (next_pc),
    .mem_addr   (mem_addr),
    .store_data (store_data),
    .store_mask (store_mask),
    .halt       (halt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= '0;
      halted      <= 1'b0;
      cycle_count <= '0;
    end else if (!halted) begin
      pc          <= next_pc;
      halted      <= halt;
      cycle_count <= cycle_count + 32'd1;
    end
  end

  // Data memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (reset && !halted) begin
      for (int i = 0; i < 4; i++)
        if (store_mask[i]) dmem[mem_addr[DA+1:2]][8*i +: 8] <= store_data[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_riscv_cpu.sv
// Scoreboard bench for riscv_cpu: directed programs, expected architectural state queued
// by the stimulus process and checked by an independent monitor at falling edges.
module tb_riscv_cpu;
  localparam logic [6:0]  LUI = 7'h37, AUIPC = 7'h17, JALR = 7'h67, LOAD = 7'h03, IMM = 7'h13;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam int K_REG = 0, K_CNT = 1, K_PC = 2, K_HALT = 3;

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } chk_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cycle_count;
  chk_t        sb[$];
  logic [31:0] prog[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  riscv_cpu #(.MEMFILE(""), .IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
    .clk         (clk),
    .reset       (reset),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] i_t(int imm, int rs1, int f3, int rd, logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] r_t(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] s_t(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] b_t(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] u_t(int imm, int rd, logic [6:0] op);
    return {imm[19:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] j_t(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction

  function automatic logic [31:0] probe(int kind, int idx);
    case (kind)
      K_REG:   return dut.exec_unit.rf.regs[idx[4:0]];
      K_CNT:   return cycle_count;
      K_PC:    return dut.pc;
      default: return {31'b0, dut.halted};
    endcase
  endfunction

  task automatic push_chk(string name, int kind, int idx, logic [31:0] exp);
    chk_t c;
    c.name = name; c.kind = kind; c.idx = idx; c.exp = exp;
    sb.push_back(c);
  endtask

  task automatic push_reg(string tag, int r, logic [31:0] exp);
    push_chk($sformatf("%s_x%0d", tag, r), K_REG, r, exp);
  endtask

  task automatic put(logic [31:0] w);
    prog.push_back(w);
  endtask

  task automatic load_prog();
    reset = 1'b0;
    for (int i = 0; i < 256; i++)
      dut.imem[i[7:0]] = (i < prog.size()) ? prog[i] : EBREAK;
    prog.delete();
  endtask

  task automatic run(int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: architectural state only changes at rising edges, so sample at falling ones.
  initial begin
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() != 0) begin
        c   = sb.pop_front();
        act = probe(c.kind, c.idx);
        n_cmp++;
        if (act !== c.exp) begin
          n_bad++;
          $display("FAIL %s: got 0x%08h, want 0x%08h", c.name, act, c.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // ALU / immediates, EBREAK at word 5
    put(i_t(-5, 0, 0, 1, IMM));
    put(i_t(32'h401, 1, 5, 2, IMM));
    put(r_t(0, 1, 0, 3, 3));
    put(u_t(32'h12345, 4, LUI));
    put(i_t(7, 0, 0, 0, IMM));
    put(EBREAK);
    #2 load_prog();
    repeat (2) @(posedge clk);
    push_chk("reset_cnt", K_CNT, 0, 32'd0);
    push_chk("reset_pc", K_PC, 0, 32'd0);
    for (int r = 1; r < 32; r++) push_reg("reset", r, 32'd0);
    drain();

    run(10);
    push_reg("alu", 0, 32'd0);
    push_reg("alu", 1, 32'hFFFF_FFFB);
    push_reg("alu", 2, 32'hFFFF_FFFD);
    push_reg("alu", 3, 32'd1);
    push_reg("alu", 4, 32'h1234_5000);
    push_chk("halt_cnt", K_CNT, 0, 32'd6);
    push_chk("halt_flag", K_HALT, 0, 32'd1);
    drain();
    repeat (5) @(posedge clk);
    push_chk("halt_cnt_frozen", K_CNT, 0, 32'd6);
    drain();

    @(negedge clk);
    reset = 1'b0;
    push_chk("rearm_cnt", K_CNT, 0, 32'd0);
    push_chk("rearm_pc", K_PC, 0, 32'd0);
    push_chk("rearm_halt", K_HALT, 0, 32'd0);
    push_reg("rearm", 1, 32'd0);
    drain();
    run(10);
    push_reg("rerun", 1, 32'hFFFF_FFFB);
    push_chk("rerun_cnt", K_CNT, 0, 32'd6);
    drain();

    // Byte-lane loads and stores
    put(u_t(32'hA1B2C, 1, LUI));
    put(i_t(32'h3D4, 1, 0, 1, IMM));
    put(s_t(8, 1, 0, 2));
    put(i_t(9, 0, 0, 2, LOAD));
    put(i_t(9, 0, 4, 3, LOAD));
    put(i_t(9, 0, 1, 4, LOAD));
    put(i_t(9, 0, 5, 5, LOAD));
    put(i_t(32'h55, 0, 0, 6, IMM));
    put(s_t(10, 6, 0, 0));
    put(i_t(8, 0, 2, 7, LOAD));
    put(s_t(12, 0, 0, 2));
    put(s_t(14, 6, 0, 1));
    put(i_t(12, 0, 2, 8, LOAD));
    put(i_t(11, 0, 1, 9, LOAD));
    put(EBREAK);
    load_prog();
    run(20);
    push_reg("mem", 1, 32'hA1B2_C3D4);
    push_reg("mem", 2, 32'hFFFF_FFC3);
    push_reg("mem", 3, 32'h0000_00C3);
    push_reg("mem", 4, 32'hFFFF_C3D4);
    push_reg("mem", 5, 32'h0000_C3D4);
    push_reg("mem", 7, 32'hA155_C3D4);
    push_reg("mem", 8, 32'h0055_0000);
    push_reg("mem", 9, 32'hFFFF_A155);
    push_chk("mem_cnt", K_CNT, 0, 32'd15);
    drain();

    // Control flow: BNE loop, JAL skip, JALR odd target, signed/unsigned branches
    put(i_t(3, 0, 0, 5, IMM));
    put(i_t(0, 0, 0, 6, IMM));
    put(i_t(1, 6, 0, 6, IMM));
    put(i_t(-1, 5, 0, 5, IMM));
    put(b_t(-8, 0, 5, 1));
    put(j_t(8, 1));
    put(i_t(99, 0, 0, 7, IMM));
    put(i_t(41, 0, 0, 8, IMM));
    put(i_t(45, 0, 0, 9, IMM));
    put(i_t(0, 9, 0, 10, JALR));
    put(i_t(77, 0, 0, 7, IMM));
    put(i_t(-1, 0, 0, 11, IMM));
    put(b_t(8, 11, 0, 6));
    put(i_t(1, 0, 0, 12, IMM));
    put(b_t(8, 11, 0, 4));
    put(i_t(2, 0, 0, 13, IMM));
    put(b_t(8, 11, 0, 5));
    put(i_t(3, 0, 0, 14, IMM));
    put(EBREAK);
    load_prog();
    run(5);
    push_chk("mid_cnt", K_CNT, 0, 32'd5);
    push_chk("mid_halt", K_HALT, 0, 32'd0);
    push_reg("mid", 5, 32'd2);
    push_reg("mid", 6, 32'd1);
    drain();
    @(negedge clk);
    reset = 1'b0;
    push_chk("midrst_cnt", K_CNT, 0, 32'd0);
    push_chk("midrst_pc", K_PC, 0, 32'd0);
    push_reg("midrst", 6, 32'd0);
    drain();
    run(30);
    push_reg("ctl", 5, 32'd0);
    push_reg("ctl", 6, 32'd3);
    push_reg("ctl", 1, 32'd24);
    push_reg("ctl", 7, 32'd0);
    push_reg("ctl", 8, 32'd41);
    push_reg("ctl", 10, 32'd40);
    push_reg("ctl", 12, 32'd0);
    push_reg("ctl", 13, 32'd2);
    push_reg("ctl", 14, 32'd0);
    push_chk("ctl_cnt", K_CNT, 0, 32'd21);
    drain();

    // 2x2 matrix multiply with MUL/ADD, then AUIPC
    for (int r = 1; r <= 8; r++) put(i_t(r, 0, 0, r, IMM));
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        put(r_t(1, 5 + j, 1 + 2 * i, 0, 15));
        put(r_t(1, 7 + j, 2 + 2 * i, 0, 16));
        put(r_t(0, 16, 15, 0, 11 + 2 * i + j));
      end
    put(u_t(2, 20, AUIPC));
    put(EBREAK);
    load_prog();
    run(30);
    push_reg("mm", 11, 32'd19);
    push_reg("mm", 12, 32'd22);
    push_reg("mm", 13, 32'd43);
    push_reg("mm", 14, 32'd50);
    push_reg("mm", 20, 32'h0000_2050);
    push_chk("mm_cnt", K_CNT, 0, 32'd22);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
